rr_arbiter_16: RTL and testbench
================================

// Module: rr_arbiter_16
// PURPOSE
//  Round-robin arbiter sharing one 16-way resource (16-to-4 encoded select path) among 16 requesters.
//  Picks one active request per arbitration, drives a one-hot grant plus its 4-bit encoded index,
//  holds the grant until the owner releases or a hold limit expires, then rotates priority.
//  Sits in front of the 16x4 encoder datapath; its index output is the encoder select.
// PARAMETERS
//  N         16  number of requesters (fixed at 16; index width derives from it)
//  IDXW      4   grant index width, = clog2(N)
//  MAX_HOLD  8   max cycles a grant may be held before forced release (1..255)
// PORTS
//  clk          in   1     rising-edge clock
//  rst_n        in   1     asynchronous active-low reset
//  req          in   16    request vector, bit i = requester i
//  done         in   1     current owner releases grant (sampled only in GRANT state)
//  grant        out  16    one-hot grant; all-zero when no owner
//  grant_idx    out  4     encoded index of grant bit; 0 when grant_valid=0
//  grant_valid  out  1     1 while a grant is active
//  timeout      out  1     1-cycle pulse when a grant is force-released by MAX_HOLD
//  lock         in   1     only with ARB_LOCK_EN (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (async, rst_n=0): grant=0, grant_idx=0, grant_valid=0, timeout=0, ptr=0, hold_cnt=0,
//    state=IDLE. Reset mid-grant drops the grant immediately, no release handshake.
//  - All outputs registered. State machine: IDLE, GRANT.
//  - IDLE: if req!=0, pick first set bit scanning ptr, ptr+1, ..., 15, 0, ..., ptr-1 (mod 16).
//    Next edge: grant[w]=1, grant_idx=w, grant_valid=1, hold_cnt=1, state=GRANT. Latency req->grant = 1 clk.
//    req==0: stay IDLE, outputs 0.
//  - GRANT: release on first edge where any holds: done=1; req[w]=0; hold_cnt==MAX_HOLD.
//    On release: grant/grant_idx/grant_valid->0, ptr=(w+1) mod 16 (15 wraps to 0), state=IDLE.
//    Otherwise hold_cnt increments (saturating at MAX_HOLD).
//  - timeout=1 for exactly the cycle after a release caused solely by hold_cnt==MAX_HOLD
//    (done=0 and req[w]=1). If done=1 or req drop coincides with limit, timeout stays 0.
//  - Minimum one IDLE cycle between consecutive grants (back-to-back grants 2 clks apart).
//  - done in IDLE ignored. req changes on non-owner bits during GRANT ignored until next IDLE.
//  - grant is always one-hot or zero; grant_idx always matches grant bit position.
// CONFIGURATION
//  ARB_LOCK_EN defined: port lock present. While in GRANT with lock=1, MAX_HOLD limit is
//    disabled (hold_cnt frozen, no timeout); done or req drop still release. lock ignored in IDLE.
//  ARB_LOCK_EN undefined: no lock port; MAX_HOLD limit always enforced.
// TESTING
//  1. rst_n=0 mid-grant (grant=16'h0010) -> all outputs 0 asynchronously; after release, req=16'h0001
//     -> grant=16'h0001, grant_idx=0 one clk later (ptr reset to 0).
//  2. req=16'hFFFF held, done pulsed each grant -> grant_idx sequence 0,1,2,...,15,0 (wrap), one IDLE gap each.
//  3. req=16'h8004, ptr=0 -> idx 2; done -> next idx 15; done -> idx 2 (rotation, skips zeros).
//  4. req=16'h0020 held, done=0, MAX_HOLD=8 -> grant valid 8 clks, then released, timeout=1 one clk,
//     regrant idx 5 after IDLE cycle.
//  5. Owner drops req[3] mid-grant, done=0 -> release next edge, timeout=0; done=1 in IDLE -> no effect.
//  6. ARB_LOCK_EN: lock=1, req=16'h0100 held 20 clks -> grant held all 20, timeout never asserts;
//     lock=0 -> release after MAX_HOLD counted from grant.

Source files
------------

// File: rtl/rr_arbiter_16.sv
// Round-robin arbiter for 16 requesters with one-hot grant, encoded index and hold-limit release.
// Optional feature: define ARB_LOCK_EN to add the lock input, which suspends the hold limit.
module rr_arbiter_16 #(
    parameter int unsigned N        = 16,
    parameter int unsigned IDXW     = 4,
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req,
    input  logic            done,
`ifdef ARB_LOCK_EN
    input  logic            lock,
`endif
    output logic [N-1:0]    grant,
    output logic [IDXW-1:0] grant_idx,
    output logic            grant_valid,
    output logic            timeout
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [N-1:0]    r_grant, w_grant_nxt;
    logic [IDXW-1:0] r_idx, w_idx_nxt;
    logic            r_valid, w_valid_nxt;
    logic            r_timeout, w_timeout_nxt;
    logic [IDXW-1:0] r_ptr, w_ptr_nxt;
    logic [7:0]      r_hold_cnt, w_hold_nxt;

    logic            w_any;
    logic [IDXW-1:0] w_pick;
    logic [IDXW-1:0] w_cand;
    logic            w_limit_active;
    logic            w_limit_hit;
    logic            w_release;

`ifdef ARB_LOCK_EN
    assign w_limit_active = ~lock;
`else
    assign w_limit_active = 1'b1;
`endif

    // Scan starts at r_ptr; truncation to IDXW bits gives the mod-N wrap.
    always_comb begin
        w_any  = 1'b0;
        w_pick = '0;
        w_cand = '0;
        for (int unsigned i = 0; i < N; i++) begin
            w_cand = IDXW'(32'(r_ptr) + i);
            if (!w_any && req[w_cand]) begin
                w_any  = 1'b1;
                w_pick = w_cand;
            end
        end
    end

    assign w_limit_hit = w_limit_active && (r_hold_cnt == 8'(MAX_HOLD));
    assign w_release   = done || !req[r_idx] || w_limit_hit;

    always_comb begin
        w_state_nxt   = r_state;
        w_grant_nxt   = r_grant;
        w_idx_nxt     = r_idx;
        w_valid_nxt   = r_valid;
        w_timeout_nxt = 1'b0;
        w_ptr_nxt     = r_ptr;
        w_hold_nxt    = r_hold_cnt;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_nxt = GRANT;
                    w_grant_nxt = N'(1) << w_pick;
                    w_idx_nxt   = w_pick;
                    w_valid_nxt = 1'b1;
                    w_hold_nxt  = 8'd1;
                end else begin
                    w_grant_nxt = '0;
                    w_idx_nxt   = '0;
                    w_valid_nxt = 1'b0;
                end
            end
            GRANT: begin
                if (w_release) begin
                    w_state_nxt   = IDLE;
                    w_grant_nxt   = '0;
                    w_idx_nxt     = '0;
                    w_valid_nxt   = 1'b0;
                    w_ptr_nxt     = r_idx + IDXW'(1);
                    w_timeout_nxt = w_limit_hit && !done && req[r_idx];
                end else if (w_limit_active && (r_hold_cnt != 8'(MAX_HOLD))) begin
                    w_hold_nxt = r_hold_cnt + 8'd1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_grant    <= '0;
            r_idx      <= '0;
            r_valid    <= 1'b0;
            r_timeout  <= 1'b0;
            r_ptr      <= '0;
            r_hold_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_grant    <= w_grant_nxt;
            r_idx      <= w_idx_nxt;
            r_valid    <= w_valid_nxt;
            r_timeout  <= w_timeout_nxt;
            r_ptr      <= w_ptr_nxt;
            r_hold_cnt <= w_hold_nxt;
        end
    end

    assign grant       = r_grant;
    assign grant_idx   = r_idx;
    assign grant_valid = r_valid;
    assign timeout     = r_timeout;

endmodule

// File: tb/tb_rr_arbiter_16.sv
// Directed bench for rr_arbiter_16: vector table for rotation/release cases plus hand sequences.
// Lock scenario runs only when ARB_LOCK_EN is defined for both bench and design.
module tb_rr_arbiter_16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] req = '0;
    logic        done = 1'b0;
`ifdef ARB_LOCK_EN
    logic        lock = 1'b0;
`endif
    logic [15:0] grant;
    logic [3:0]  grant_idx;
    logic        grant_valid;
    logic        timeout;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;

    rr_arbiter_16 #(.N(16), .IDXW(4), .MAX_HOLD(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .done        (done),
`ifdef ARB_LOCK_EN
        .lock        (lock),
`endif
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] req;
        logic        done;
        logic [15:0] g;
        logic [3:0]  idx;
        logic        v;
        logic        to;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else
            n_pass++;
    endtask

    task automatic check_out(input string name, input logic [15:0] g, input logic [3:0] idx,
                             input logic v, input logic to);
        check({name, ".grant"},       32'(grant),       32'(g));
        check({name, ".grant_idx"},   32'(grant_idx),   32'(idx));
        check({name, ".grant_valid"}, 32'(grant_valid), 32'(v));
        check({name, ".timeout"},     32'(timeout),     32'(to));
    endtask

    task automatic step(input logic [15:0] r, input logic d);
        req  = r;
        done = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        done  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // Rotation with skipped zeros, owner drop, done in IDLE, non-owner changes.
        vecs[0]  = '{16'h8004, 1'b0, 16'h0004, 4'd2,  1'b1, 1'b0};
        vecs[1]  = '{16'h8004, 1'b1, 16'h0000, 4'd0,  1'b0, 1'b0};
        vecs[2]  = '{16'h8004, 1'b0, 16'h8000, 4'd15, 1'b1, 1'b0};
        vecs[3]  = '{16'h8004, 1'b1, 16'h0000, 4'd0,  1'b0, 1'b0};
        vecs[4]  = '{16'h8004, 1'b0, 16'h0004, 4'd2,  1'b1, 1'b0};
        vecs[5]  = '{16'h8004, 1'b1, 16'h0000, 4'd0,  1'b0, 1'b0};
        vecs[6]  = '{16'h0008, 1'b0, 16'h0008, 4'd3,  1'b1, 1'b0};
        vecs[7]  = '{16'h0008, 1'b0, 16'h0008, 4'd3,  1'b1, 1'b0};
        vecs[8]  = '{16'h0000, 1'b0, 16'h0000, 4'd0,  1'b0, 1'b0};
        vecs[9]  = '{16'h0000, 1'b1, 16'h0000, 4'd0,  1'b0, 1'b0};
        vecs[10] = '{16'h0000, 1'b1, 16'h0000, 4'd0,  1'b0, 1'b0};
        vecs[11] = '{16'h0010, 1'b0, 16'h0010, 4'd4,  1'b1, 1'b0};
        vecs[12] = '{16'h0011, 1'b0, 16'h0010, 4'd4,  1'b1, 1'b0};
        vecs[13] = '{16'h0011, 1'b1, 16'h0000, 4'd0,  1'b0, 1'b0};
        vecs[14] = '{16'h0011, 1'b0, 16'h0001, 4'd0,  1'b1, 1'b0};
        vecs[15] = '{16'h0011, 1'b1, 16'h0000, 4'd0,  1'b0, 1'b0};
        vecs[16] = '{16'h0000, 1'b0, 16'h0000, 4'd0,  1'b0, 1'b0};

        // Reset state, then asynchronous reset in the middle of a grant.
        do_reset();
        #1;
        check_out("reset", 16'h0000, 4'd0, 1'b0, 1'b0);
        step(16'h0010, 1'b0);
        check_out("t1_grant", 16'h0010, 4'd4, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_out("t1_async_rst", 16'h0000, 4'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step(16'h0001, 1'b0);
        check_out("t1_ptr_reset", 16'h0001, 4'd0, 1'b1, 1'b0);

        do_reset();
        for (int i = 0; i < 17; i++) begin
            step(vecs[i].req, vecs[i].done);
            check_out($sformatf("vec%0d", i), vecs[i].g, vecs[i].idx, vecs[i].v, vecs[i].to);
        end

        // Hold-limit timeout on idx 5 (ptr=1 here), regrant, then done coinciding with the limit.
        for (int k = 1; k <= 8; k++) begin
            step(16'h0020, 1'b0);
            check_out($sformatf("t4_hold%0d", k), 16'h0020, 4'd5, 1'b1, 1'b0);
        end
        step(16'h0020, 1'b0);
        check_out("t4_timeout", 16'h0000, 4'd0, 1'b0, 1'b1);
        step(16'h0020, 1'b0);
        check_out("t4_regrant", 16'h0020, 4'd5, 1'b1, 1'b0);
        for (int k = 2; k <= 8; k++) begin
            step(16'h0020, 1'b0);
            check_out($sformatf("t4b_hold%0d", k), 16'h0020, 4'd5, 1'b1, 1'b0);
        end
        step(16'h0020, 1'b1);
        check_out("t4b_done_at_limit", 16'h0000, 4'd0, 1'b0, 1'b0);

        // Full rotation with wrap, one IDLE gap between grants.
        do_reset();
        for (int i = 0; i < 17; i++) begin
            step(16'hFFFF, 1'b1);
            check_out($sformatf("t2_grant%0d", i), 16'(1) << (i % 16), 4'(i % 16), 1'b1, 1'b0);
            step(16'hFFFF, 1'b1);
            check_out($sformatf("t2_gap%0d", i), 16'h0000, 4'd0, 1'b0, 1'b0);
        end

`ifdef ARB_LOCK_EN
        do_reset();
        lock = 1'b1;
        step(16'h0100, 1'b0);
        check_out("t6_grant", 16'h0100, 4'd8, 1'b1, 1'b0);
        for (int k = 0; k < 20; k++) begin
            step(16'h0100, 1'b0);
            check_out($sformatf("t6_lock%0d", k), 16'h0100, 4'd8, 1'b1, 1'b0);
        end
        lock = 1'b0;
        for (int k = 0; k < 7; k++) begin
            step(16'h0100, 1'b0);
            check_out($sformatf("t6_unlock%0d", k), 16'h0100, 4'd8, 1'b1, 1'b0);
        end
        step(16'h0100, 1'b0);
        check_out("t6_timeout", 16'h0000, 4'd0, 1'b0, 1'b1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
